// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers 8-bit audio samples in a small FIFO and plays each one
// as the duty cycle of one 256-tick PWM period.
// Optional build macro AUDIO_PWM_HOLD_LAST_EN: on underrun keep the previous
// duty instead of dropping to mid-scale (0x80).
//
// state  | meaning
// S_IDLE | waiting for the first sample; cnt parked at 255, output low
// S_RUN  | PWM active; a new duty is taken at every period boundary
module audio_pwm_out #(
    parameter int PRESCALE   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      wave,
    input  logic                            wave_valid,
    output logic                            wave_ready,
    output logic                            pwm_out,
    output logic                            underrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      duty_q, duty_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic            pwm_q, pwm_d;
    logic            underrun_q, underrun_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            tick;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [7:0]      head;

    assign wave_ready = (count_q < LW'(FIFO_DEPTH));
    assign push       = wave_valid && wave_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign tick       = (presc_q == PSW'(PRESCALE - 1));

    assign pwm_out    = pwm_q;
    assign underrun   = underrun_q;
    assign fifo_level = count_q;

    // Sequencing FSM, PWM counter, duty selection and FIFO pointer arithmetic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        presc_d    = tick ? '0 : presc_q + PSW'(1);

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = 8'hFF;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        duty_d  = head;
                        cnt_d   = 8'h00;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'hFF) begin
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            duty_d = head;
                        end else begin
                            underrun_d = 1'b1;
`ifdef AUDIO_PWM_HOLD_LAST_EN
                            duty_d = duty_q;
`else
                            duty_d = 8'h80;
`endif
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pwm_d    = (state_q == S_RUN) && (cnt_q < duty_q);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'hFF;
            duty_q     <= 8'h00;
            presc_q    <= '0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            presc_q    <= presc_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Sample storage; contents are don't-care while the occupancy count is zero.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wave;
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out with PRESCALE = 1, FIFO_DEPTH = 4.
module tb_audio_pwm_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wave = 8'h00;
    logic       wave_valid = 1'b0;
    logic       wave_ready;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_level;

    int checks = 0;
    int passes = 0;
    int hi, fl, uc, ui, rdy_hi;

`ifdef AUDIO_PWM_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    audio_pwm_out #(.PRESCALE(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wave       (wave),
        .wave_valid (wave_valid),
        .wave_ready (wave_ready),
        .pwm_out    (pwm_out),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wave_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Samples n consecutive cycles: high count, index of first low, underrun pulses.
    task automatic measure(input int n, output int h, output int first_low,
                           output int ur_cnt, output int ur_idx);
        h = 0; first_low = n; ur_cnt = 0; ur_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (pwm_out === 1'b1) h++;
            else if (first_low == n) first_low = i;
            if (underrun === 1'b1) begin
                ur_cnt++;
                ur_idx = i;
            end
            step();
        end
    endtask

    function automatic int ur_duty(input int prev);
        return HOLD ? prev : 128;
    endfunction

    initial begin
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_pwm", pwm_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", wave_ready, 1);

        // single sample 0x40
        wave = 8'h40; wave_valid = 1'b1;
        step();
        wave_valid = 1'b0;
        check("single_level_push", fifo_level, 1);
        step();
        check("single_level_pop", fifo_level, 0);
        step();
        measure(256, hi, fl, uc, ui);
        check("single_hi", hi, 64);
        check("single_first_low", fl, 64);
        check("single_ur_cnt", uc, 1);
        check("single_ur_idx", ui, 255);
        check("single_ur_width", underrun, 0);
        measure(256, hi, fl, uc, ui);
        check("single_after_ur_hi", hi, ur_duty(64));
        check("single_after_ur_fl", fl, ur_duty(64));

        // underrun with 0x20 and a push landing on the empty boundary
        do_reset();
        wave = 8'h20; wave_valid = 1'b1;
        step();
        wave_valid = 1'b0;
        step();
        step();
        measure(254, hi, fl, uc, ui);
        check("ur_first_hi", hi, 32);
        check("ur_first_ur", uc, 0);
        wave = 8'h50; wave_valid = 1'b1;
        step();
        wave_valid = 1'b0;
        check("ur_boundary_pulse", underrun, 1);
        check("ur_boundary_stored", fifo_level, 1);
        step();
        measure(256, hi, fl, uc, ui);
        check("ur_second_hi", hi, ur_duty(32));
        check("ur_second_nour", uc, 0);
        measure(256, hi, fl, uc, ui);
        check("ur_third_hi", hi, 80);
        check("ur_third_fl", fl, 80);
        check("ur_third_ur_idx", ui, 255);

        // extremes 0x00 then 0xFF
        do_reset();
        wave = 8'h00; wave_valid = 1'b1;
        step();
        wave = 8'hFF;
        step();
        wave_valid = 1'b0;
        check("ext_level", fifo_level, 1);
        step();
        measure(256, hi, fl, uc, ui);
        check("ext_zero_hi", hi, 0);
        check("ext_zero_ur", uc, 0);
        measure(256, hi, fl, uc, ui);
        check("ext_full_hi", hi, 255);
        check("ext_full_fl", fl, 255);
        check("ext_full_ur_idx", ui, 255);

        // overflow: 0x11..0x55 held, 0x66 offered while full
        do_reset();
        wave = 8'h11; wave_valid = 1'b1;
        step();
        wave = 8'h22;
        step();
        check("ovf_pushpop_level", fifo_level, 1);
        wave = 8'h33;
        hi = 0; rdy_hi = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm_out === 1'b1) hi++;
            if (k == 0) wave = 8'h44;
            if (k == 1) wave = 8'h55;
            if (k == 2) begin
                check("ovf_full_level", fifo_level, 4);
                check("ovf_full_ready", wave_ready, 0);
                wave = 8'h66;
            end
            if (k >= 2 && k <= 254 && wave_ready !== 1'b0) rdy_hi++;
        end
        check("ovf_duty_11", hi, 32'h11);
        check("ovf_ready_held_low", rdy_hi, 0);
        check("ovf_boundary_level", fifo_level, 3);
        check("ovf_boundary_ready", wave_ready, 1);
        step();
        wave_valid = 1'b0;
        check("ovf_refill_level", fifo_level, 4);
        measure(256, hi, fl, uc, ui);
        check("ovf_duty_22", hi, 32'h22);
        measure(256, hi, fl, uc, ui);
        check("ovf_duty_33", hi, 32'h33);
        measure(256, hi, fl, uc, ui);
        check("ovf_duty_44", hi, 32'h44);
        measure(256, hi, fl, uc, ui);
        check("ovf_duty_55", hi, 32'h55);
        check("ovf_no_ur_yet", uc, 0);
        measure(256, hi, fl, uc, ui);
        check("ovf_duty_66", hi, 32'h66);
        check("ovf_final_ur", uc, 1);

        // reset in the middle of a period with three samples buffered
        do_reset();
        wave = 8'hA0; wave_valid = 1'b1;
        step();
        wave = 8'hB0;
        step();
        wave = 8'hC0;
        step();
        wave = 8'hD0;
        step();
        wave_valid = 1'b0;
        repeat (98) step();
        check("mid_level_before", fifo_level, 3);
        check("mid_pwm_before", pwm_out, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_pwm_after", pwm_out, 0);
        check("mid_level_after", fifo_level, 0);
        check("mid_ready_after", wave_ready, 1);
        measure(600, hi, fl, uc, ui);
        check("mid_no_stale_hi", hi, 0);
        check("mid_no_stale_ur", uc, 0);
        wave = 8'h08; wave_valid = 1'b1;
        step();
        wave_valid = 1'b0;
        step();
        step();
        measure(256, hi, fl, uc, ui);
        check("mid_restart_hi", hi, 8);
        check("mid_restart_fl", fl, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
